// File: rtl/comp8_bist.sv
// Built-in self-test sequencer for an 8-bit cascadable magnitude comparator.
// Drives LFSR and directed operand vectors, checks results against a golden model.
module comp8_bist #(
  parameter int unsigned NUM_VEC = 8,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [7:0] a,
  output logic [7:0] b,
  output logic       gt,
  output logic       lt,
  output logic       eq,
  input  logic       agtb,
  input  logic       altb,
  input  logic       aeqb,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CHECK, S_DONE} state_t;

  localparam logic [8:0] NV   = 9'(NUM_VEC);
  localparam logic [8:0] LAST = 9'(NUM_VEC + 1);

  state_t      state;
  logic [15:0] lfsr;
  logic [8:0]  vec_idx;

  logic [15:0] lfsr_next;
  logic [8:0]  nxt_idx;
  logic        exp_gt, exp_lt, exp_eq, mismatch;
  logic [7:0]  err_next;
  logic [7:0]  nxt_a, nxt_b;
  logic        nxt_gt, nxt_lt, nxt_eq;

  // Golden comparison, error accumulation and next-vector selection
  always_comb begin
    lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    nxt_idx   = vec_idx + 9'd1;
    exp_gt    = (a > b) | ((a == b) & gt);
    exp_lt    = (a < b) | ((a == b) & lt);
    exp_eq    = (a == b) & eq;
    mismatch  = (agtb != exp_gt) | (altb != exp_lt) | (aeqb != exp_eq);
    if (mismatch && (err_cnt != 8'hFF)) begin
      err_next = err_cnt + 8'd1;
    end else begin
      err_next = err_cnt;
    end
    // Random vectors first, then equal operands with eq cascade, then with gt cascade
    if (nxt_idx < NV) begin
      nxt_a  = lfsr_next[15:8];
      nxt_b  = lfsr_next[7:0];
      nxt_gt = 1'b0;
      nxt_lt = 1'b0;
      nxt_eq = 1'b1;
    end else if (nxt_idx == NV) begin
      nxt_a  = 8'd5;
      nxt_b  = 8'd5;
      nxt_gt = 1'b0;
      nxt_lt = 1'b0;
      nxt_eq = 1'b1;
    end else begin
      nxt_a  = 8'd5;
      nxt_b  = 8'd5;
      nxt_gt = 1'b1;
      nxt_lt = 1'b0;
      nxt_eq = 1'b0;
    end
  end

  // Sequencer FSM with registered operand and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      lfsr    <= SEED;
      vec_idx <= 9'd0;
      a       <= 8'd0;
      b       <= 8'd0;
      gt      <= 1'b0;
      lt      <= 1'b0;
      eq      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      err_cnt <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state   <= S_DRIVE;
            busy    <= 1'b1;
            lfsr    <= SEED;
            vec_idx <= 9'd0;
            a       <= SEED[15:8];
            b       <= SEED[7:0];
            gt      <= 1'b0;
            lt      <= 1'b0;
            eq      <= 1'b1;
            err_cnt <= 8'd0;
            pass    <= 1'b0;
          end
        end
        S_DRIVE: begin
          state <= S_CHECK;
        end
        S_CHECK: begin
          err_cnt <= err_next;
          lfsr    <= lfsr_next;
          if (vec_idx == LAST) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
            pass  <= (err_next == 8'd0);
          end else begin
            state   <= S_DRIVE;
            vec_idx <= nxt_idx;
            a       <= nxt_a;
            b       <= nxt_b;
            gt      <= nxt_gt;
            lt      <= nxt_lt;
            eq      <= nxt_eq;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comp8_bist.sv
// Scoreboard bench for comp8_bist: a modelled comparator with selectable faults is attached,
// each run pushes its expected completion, a monitor checks every done pulse.
module tb_comp8_bist;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, start1 = 1'b0;
  logic [7:0] a, b, a1, b1;
  logic       gt, lt, eq, gt1, lt1, eq1;
  logic       agtb, altb, aeqb;
  logic       busy, done, pass, busy1, done1, pass1;
  logic [7:0] err_cnt, err_cnt1;
  logic [1:0] mode = 2'd0;
  int         cyc = 0;
  int         nvec = 0;
  int         nfail = 0;

  typedef struct {int dcyc; logic [7:0] err; logic pass;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  comp8_bist dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .gt(gt), .lt(lt), .eq(eq),
    .agtb(agtb), .altb(altb), .aeqb(aeqb), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt)
  );

  comp8_bist #(.NUM_VEC(255)) dut_sat (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .gt(gt1), .lt(lt1), .eq(eq1),
    .agtb(1'b0), .altb(1'b0), .aeqb(1'b0), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err_cnt1)
  );

  // Comparator under test: 0 good, 1 agtb stuck 0, 2 aeqb stuck 1, 3 all outputs 0
  always_comb begin
    agtb = (a > b) | ((a == b) & gt);
    altb = (a < b) | ((a == b) & lt);
    aeqb = (a == b) & eq;
    if (mode == 2'd1) agtb = 1'b0;
    if (mode == 2'd2) aeqb = 1'b1;
    if (mode == 2'd3) begin
      agtb = 1'b0;
      altb = 1'b0;
      aeqb = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected mismatch count for a default-length run under a fault mode
  function automatic logic [7:0] exp_err(input int m);
    logic [15:0] l = 16'hACE1;
    int n = 0;
    for (int k = 0; k < 8; k++) begin
      if (m == 1 && l[15:8] > l[7:0]) n++;
      if (m == 2 && l[15:8] != l[7:0]) n++;
      if (m == 3) n++;
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    end
    if (m != 0) n++;
    if (m == 3) n++;
    return 8'(n);
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        nvec++;
        nfail++;
        $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cycle", cyc, e.dcyc);
        chk("err_cnt", {24'd0, err_cnt}, {24'd0, e.err});
        chk("pass", {31'd0, pass}, {31'd0, e.pass});
      end
    end
  end

  task automatic run(input logic [1:0] m, input bit push);
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    if (push) sb.push_back('{cyc + 21, exp_err(int'(m)), exp_err(int'(m)) == 8'd0});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy && !done) return;
    end
    chk("timeout_idle", 32'd1, 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pass", {31'd0, pass}, 32'd0);
    chk("rst_err", {24'd0, err_cnt}, 32'd0);
    chk("rst_ab", {16'd0, a, b}, 32'd0);
    chk("rst_cascade", {29'd0, gt, lt, eq}, 32'd1);

    // Good comparator: first vector comes straight from the seed
    run(2'd0, 1'b1);
    chk("first_a", {24'd0, a}, 32'hAC);
    chk("first_b", {24'd0, b}, 32'hE1);
    chk("first_busy", {31'd0, busy}, 32'd1);
    chk("first_cascade", {29'd0, gt, lt, eq}, 32'd1);
    wait_idle(40);

    run(2'd1, 1'b1);
    wait_idle(40);
    run(2'd2, 1'b1);
    wait_idle(40);

    // Second start mid-run must be ignored
    run(2'd0, 1'b1);
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(40);

    // Reset during CHECK of the fourth vector, after three mismatches have been counted
    run(2'd3, 1'b0);
    repeat (7) @(negedge clk);
    chk("pre_rst_err", {24'd0, err_cnt}, 32'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_err", {24'd0, err_cnt}, 32'd0);
    chk("mid_rst_a", {24'd0, a}, 32'd0);
    chk("mid_rst_eq", {31'd0, eq}, 32'd1);
    repeat (30) @(negedge clk);
    run(2'd0, 1'b1);
    wait_idle(40);

    // Start held high re-triggers a second run two cycles after done
    @(negedge clk);
    mode  = 2'd0;
    start = 1'b1;
    sb.push_back('{cyc + 21, 8'd0, 1'b1});
    sb.push_back('{cyc + 43, 8'd0, 1'b1});
    repeat (23) @(negedge clk);
    start = 1'b0;
    wait_idle(40);

    // All-zero comparator over 257 vectors saturates the error counter
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 600 && !seen; i++) begin
        @(negedge clk);
        if (done1) seen = 1'b1;
      end
      chk("sat_done_seen", {31'd0, seen}, 32'd1);
      chk("sat_err", {24'd0, err_cnt1}, 32'hFF);
      chk("sat_pass", {31'd0, pass1}, 32'd0);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/comp8_bist.md
COMP8_BIST -- requirements
Module: comp8_bist

Interface
REQ-001 Parameter NUM_VEC, default 8, number of pseudo-random operand pairs per run (1..255).
REQ-002 Parameter SEED, default 16'hACE1, LFSR load value, nonzero.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  run request, sampled only in IDLE.
REQ-006 a  output  8  operand A driven to the comparator under test.
REQ-007 b  output  8  operand B driven to the comparator under test.
REQ-008 gt  output  1  cascade greater-than input to the comparator.
REQ-009 lt  output  1  cascade less-than input to the comparator.
REQ-010 eq  output  1  cascade equal input to the comparator.
REQ-011 agtb  input  1  comparator result, A greater than B.
REQ-012 altb  input  1  comparator result, A less than B.
REQ-013 aeqb  input  1  comparator result, A equal to B.
REQ-014 busy  output  1  high from the cycle after start acceptance until DONE.
REQ-015 done  output  1  one-cycle pulse at run completion.
REQ-016 pass  output  1  high when the last completed run had zero mismatches.
REQ-017 err_cnt  output  8  mismatch count of the current or last run.

Function
REQ-018 FSM states IDLE, DRIVE, CHECK, DONE; IDLE->DRIVE on start=1; DRIVE->CHECK unconditionally; CHECK->DRIVE while vectors remain, else ->DONE; DONE->IDLE unconditionally.
REQ-019 Vector sequence per run: NUM_VEC LFSR vectors, then directed vector D1 (a=b=8'd5, gt=0, lt=0, eq=1), then D2 (a=b=8'd5, gt=1, lt=0, eq=0); total NUM_VEC+2.
REQ-020 LFSR is 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, loaded with SEED on start acceptance; random vector k drives a=lfsr[15:8], b=lfsr[7:0]; LFSR advances once per CHECK.
REQ-021 During random vectors gt=0, lt=0, eq=1.
REQ-022 a, b, gt, lt, eq are registered, updated on entry to DRIVE, held stable through the following CHECK.
REQ-023 Comparator under test is treated as combinational; agtb/altb/aeqb are sampled on the edge ending CHECK.
REQ-024 Golden: exp_gt=(a>b)|((a==b)&gt); exp_lt=(a<b)|((a==b)&lt); exp_eq=(a==b)&eq; unsigned 8-bit compare.
REQ-025 A vector mismatches if any of the three sampled results differs from golden; each mismatching vector increments err_cnt by exactly 1.
REQ-026 err_cnt saturates at 8'hFF, no wrap.
REQ-027 err_cnt cleared to 0 on start acceptance; pass cleared to 0 on start acceptance.
REQ-028 In DONE, done=1 for one cycle and pass loaded with (err_cnt==0); pass and err_cnt then held until next start or reset.
REQ-029 Latency: done asserts exactly 2*(NUM_VEC+2) cycles after the edge that accepts start (20 cycles at default).
REQ-030 start while busy or in DONE is ignored; no restart, no queuing.
REQ-031 start held high continuously re-triggers a new run from IDLE after each DONE.

Reset
REQ-032 On rst=1 at a rising edge: state=IDLE, a=0, b=0, gt=0, lt=0, eq=1, busy=0, done=0, pass=0, err_cnt=0, LFSR=SEED.
REQ-033 rst has priority over start and over any in-progress run; a run interrupted by rst does not produce done.

Verification
REQ-034 Correct comparator attached, defaults, pulse start -> first vector a=8'hAC, b=8'hE1; done after 20 cycles; pass=1, err_cnt=0.
REQ-035 Comparator with agtb stuck at 0 -> D2 fails plus every random vector with a>b fails; pass=0, err_cnt equals that count.
REQ-036 Comparator with aeqb stuck at 1 -> all random vectors with a!=b and D2 fail; D1 passes; pass=0.
REQ-037 Assert rst during CHECK of vector 3 -> next cycle busy=0, err_cnt=0, a=0, eq=1; no done pulse; subsequent start runs full 20-cycle sequence.
REQ-038 Pulse start again at cycle 5 of an active run -> ignored; done still at cycle 20 of the original run.
REQ-039 Comparator returning all three results 0 with NUM_VEC=255 -> err_cnt saturates at 8'hFF, pass=0.
